// File: rtl/chess_clock_multi_pkg.sv
// Shared types and helpers for the multi-player game clock.
package chess_clock_multi_pkg;

  // Game-level control state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } clk_state_e;

  // Timing modes selectable through the MODE parameter.
  localparam int MODE_SUDDEN  = 0;
  localparam int MODE_FISCHER = 1;
  localparam int MODE_DELAY   = 2;

  // Width of a counter that holds 0..n-1, never narrower than one bit.
  function automatic int clk_count_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chess_clock_multi_if.sv
// Control and status bundle between the button front-end, the clock and the display.
interface chess_clock_multi_if
  import chess_clock_multi_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int TIME_W      = 16
);
  localparam int PW = clk_count_w(NUM_PLAYERS);

  logic                          start;
  logic                          pause;
  logic                          load;
  logic [NUM_PLAYERS-1:0]        press;
  logic [NUM_PLAYERS*TIME_W-1:0] time_out;
  logic [NUM_PLAYERS-1:0]        flag;
  logic [PW-1:0]                 active;
  logic                          running;
  logic                          game_over;

  // Front-end side: drives the buttons, watches the clock state.
  modport master (
    output start, pause, load, press,
    input  time_out, flag, active, running, game_over
  );

  // Clock side: reacts to the buttons, publishes timers and status.
  modport slave (
    input  start, pause, load, press,
    output time_out, flag, active, running, game_over
  );

endinterface

// File: rtl/chess_clock_multi_tick_prescaler.sv
// Divides clk down to a one-cycle tick every DIV enabled cycles.
module chess_clock_multi_tick_prescaler
  import chess_clock_multi_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = clk_count_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Tick is raised during the last enabled cycle of each period.
  assign tick = en && (cnt_q == LAST);

  // Phase counter: frozen when disabled, restarted by clr (turn change).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/chess_clock_multi.sv
// N-player game clock: round-robin turns, per-player countdown timers,
// sudden-death / Fischer increment / simple delay timing.
module chess_clock_multi
  import chess_clock_multi_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int TIME_W      = 16,
  parameter int TICK_DIV    = 50000,
  parameter int INIT_TIME   = 300,
  parameter int MODE        = 0,
  parameter int INC_TIME    = 5,
  parameter int DELAY_TIME  = 3
) (
  input logic                clk,
  input logic                reset,
  chess_clock_multi_if.slave bus
);
  localparam int PW = clk_count_w(NUM_PLAYERS);
  localparam int DW = clk_count_w(DELAY_TIME + 1);
  localparam logic [TIME_W-1:0] INIT_VAL   = TIME_W'(INIT_TIME);
  localparam logic [PW-1:0]     LAST_PLYR  = PW'(NUM_PLAYERS - 1);
  localparam logic [DW-1:0]     DELAY_VAL  = DW'(DELAY_TIME);
  localparam bit                IS_FISCHER = (MODE == MODE_FISCHER);
  localparam bit                IS_DELAY   = (MODE == MODE_DELAY);

  // Timer plus the Fischer increment, clamped at the all-ones maximum.
  function automatic logic [TIME_W-1:0] sat_add_inc(input logic [TIME_W-1:0] t);
    logic [TIME_W:0] s;
    s = {1'b0, t} + (TIME_W + 1)'(INC_TIME);
    return s[TIME_W] ? {TIME_W{1'b1}} : s[TIME_W-1:0];
  endfunction

  clk_state_e             state_q, state_d;
  logic [TIME_W-1:0]      timer_q [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] flag_q;
  logic [PW-1:0]          active_q;
  logic [PW-1:0]          next_active;
  logic [DW-1:0]          dcnt_q;

  logic              run_cycle;
  logic              tick;
  logic              reload;
  logic              new_game;
  logic [TIME_W-1:0] act_time;
  logic [TIME_W-1:0] dec_time;
  logic [TIME_W-1:0] act_nxt;
  logic              in_delay;
  logic              tick_dec;
  logic              timeout;
  logic              press_ok;
  logic              act_upd;

  // Counting and presses only happen while running with pause released;
  // kept outside the FSM block so tick never loops back into it.
  assign run_cycle = (state_q == RUN) && !bus.pause;

  chess_clock_multi_tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (run_cycle),
    .clr   (press_ok),
    .tick  (tick)
  );

  // Active-player datapath: decrement on tick first, then the accepted
  // press (increment and hand-over) unless that decrement hit zero.
  always_comb begin
    act_time = timer_q[active_q];
    in_delay = IS_DELAY && (dcnt_q < DELAY_VAL);
    tick_dec = tick && !in_delay && (act_time != '0);
    dec_time = tick_dec ? act_time - 1'b1 : act_time;
    timeout  = tick_dec && (dec_time == '0);
    press_ok = run_cycle && bus.press[active_q] && !timeout;
    act_nxt  = (IS_FISCHER && press_ok) ? sat_add_inc(dec_time) : dec_time;
    act_upd  = tick_dec || (IS_FISCHER && press_ok);
    next_active = (active_q == LAST_PLYR) ? '0 : active_q + 1'b1;
  end

  // Next-state logic and load strobes, priority top-down within each state.
  always_comb begin
    state_d  = state_q;
    reload   = 1'b0;
    new_game = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          reload = 1'b1;
        end else if (bus.start && !bus.pause) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (timeout) begin
          state_d = OVER;
        end else if (bus.pause) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (bus.start && !bus.pause) begin
          state_d = RUN;
        end
      end
      OVER: begin
        if (bus.load) begin
          reload   = 1'b1;
          new_game = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timer bank: reload all on load, otherwise only the active timer moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) timer_q[i] <= INIT_VAL;
    end else if (reload) begin
      for (int i = 0; i < NUM_PLAYERS; i++) timer_q[i] <= INIT_VAL;
    end else if (act_upd) begin
      timer_q[active_q] <= act_nxt;
    end
  end

  // Turn ownership, per-turn delay count and sticky timeout flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= '0;
      dcnt_q   <= '0;
      flag_q   <= '0;
    end else if (new_game) begin
      active_q <= '0;
      dcnt_q   <= '0;
      flag_q   <= '0;
    end else begin
      if (timeout) begin
        flag_q[active_q] <= 1'b1;
      end
      if (press_ok) begin
        active_q <= next_active;
        dcnt_q   <= '0;
      end else if (tick && in_delay) begin
        dcnt_q <= dcnt_q + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_flat
    assign bus.time_out[g*TIME_W +: TIME_W] = timer_q[g];
  end

  assign bus.flag      = flag_q;
  assign bus.active    = active_q;
  assign bus.running   = (state_q == RUN);
  assign bus.game_over = (state_q == OVER);

endmodule

// File: tb/tb_chess_clock_multi.sv
// Randomised bench for chess_clock_multi: four clocks (sudden death,
// Fischer, delay, narrow saturating Fischer) share one button stream and
// are each compared every cycle with a game-rules reference model.
module tb_chess_clock_multi;
  import chess_clock_multi_pkg::*;

  localparam int N   = 3;
  localparam int DIV = 4;
  localparam int NI  = 4;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_PAUSE = 2;
  localparam int P_OVER  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_s, pause_s, load_s;
  logic [N-1:0] press_s;

  chess_clock_multi_if #(.NUM_PLAYERS(N), .TIME_W(16)) if0 ();
  chess_clock_multi_if #(.NUM_PLAYERS(N), .TIME_W(16)) if1 ();
  chess_clock_multi_if #(.NUM_PLAYERS(N), .TIME_W(16)) if2 ();
  chess_clock_multi_if #(.NUM_PLAYERS(N), .TIME_W(4))  if3 ();

  assign if0.start = start_s; assign if0.pause = pause_s; assign if0.load = load_s; assign if0.press = press_s;
  assign if1.start = start_s; assign if1.pause = pause_s; assign if1.load = load_s; assign if1.press = press_s;
  assign if2.start = start_s; assign if2.pause = pause_s; assign if2.load = load_s; assign if2.press = press_s;
  assign if3.start = start_s; assign if3.pause = pause_s; assign if3.load = load_s; assign if3.press = press_s;

  chess_clock_multi #(.NUM_PLAYERS(N), .TIME_W(16), .TICK_DIV(DIV), .INIT_TIME(5),
    .MODE(MODE_SUDDEN), .INC_TIME(5), .DELAY_TIME(3)) u_dut0 (.clk(clk), .reset(rst_n), .bus(if0));
  chess_clock_multi #(.NUM_PLAYERS(N), .TIME_W(16), .TICK_DIV(DIV), .INIT_TIME(5),
    .MODE(MODE_FISCHER), .INC_TIME(2), .DELAY_TIME(3)) u_dut1 (.clk(clk), .reset(rst_n), .bus(if1));
  chess_clock_multi #(.NUM_PLAYERS(N), .TIME_W(16), .TICK_DIV(DIV), .INIT_TIME(5),
    .MODE(MODE_DELAY), .INC_TIME(5), .DELAY_TIME(3)) u_dut2 (.clk(clk), .reset(rst_n), .bus(if2));
  chess_clock_multi #(.NUM_PLAYERS(N), .TIME_W(4), .TICK_DIV(DIV), .INIT_TIME(14),
    .MODE(MODE_FISCHER), .INC_TIME(5), .DELAY_TIME(3)) u_dut3 (.clk(clk), .reset(rst_n), .bus(if3));

  // Per-instance configuration mirrored from the parameter lists above.
  int c_mode [NI] = '{MODE_SUDDEN, MODE_FISCHER, MODE_DELAY, MODE_FISCHER};
  int c_inc  [NI] = '{0, 2, 0, 5};
  int c_dly  [NI] = '{0, 0, 3, 0};
  int c_init [NI] = '{5, 5, 5, 14};
  int c_max  [NI] = '{65535, 65535, 65535, 15};
  int c_tw   [NI] = '{16, 16, 16, 4};

  // Reference model state.
  int m_st  [NI];
  int m_tm  [NI][N];
  int m_fl  [NI][N];
  int m_act [NI];
  int m_pre [NI];
  int m_dc  [NI];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_st[k] = P_IDLE; m_act[k] = 0; m_pre[k] = 0; m_dc[k] = 0;
      for (int i = 0; i < N; i++) begin
        m_tm[k][i] = c_init[k];
        m_fl[k][i] = 0;
      end
    end
  endtask

  // One clock edge of game rules for instance k, using the current buttons.
  task automatic model_step(input int k);
    int a;
    int s;
    bit tk;
    bit to;
    a  = m_act[k];
    to = 1'b0;
    case (m_st[k])
      P_IDLE: begin
        if (load_s) begin
          for (int i = 0; i < N; i++) m_tm[k][i] = c_init[k];
        end else if (start_s && !pause_s) begin
          m_st[k] = P_RUN;
        end
      end
      P_RUN: begin
        if (pause_s) begin
          m_st[k] = P_PAUSE;
        end else begin
          tk = (m_pre[k] == DIV - 1);
          m_pre[k] = tk ? 0 : m_pre[k] + 1;
          if (tk) begin
            if (c_mode[k] == MODE_DELAY && m_dc[k] < c_dly[k]) begin
              m_dc[k]++;
            end else if (m_tm[k][a] > 0) begin
              m_tm[k][a]--;
              if (m_tm[k][a] == 0) begin
                m_fl[k][a] = 1;
                to = 1'b1;
                m_st[k] = P_OVER;
              end
            end
          end
          if (!to && press_s[a]) begin
            if (c_mode[k] == MODE_FISCHER) begin
              s = m_tm[k][a] + c_inc[k];
              m_tm[k][a] = (s > c_max[k]) ? c_max[k] : s;
            end
            m_act[k] = (a + 1) % N;
            m_dc[k]  = 0;
            m_pre[k] = 0;
          end
        end
      end
      P_PAUSE: begin
        if (start_s && !pause_s) m_st[k] = P_RUN;
      end
      default: begin
        if (load_s) begin
          for (int i = 0; i < N; i++) begin
            m_tm[k][i] = c_init[k];
            m_fl[k][i] = 0;
          end
          m_act[k] = 0;
          m_dc[k]  = 0;
          m_st[k]  = P_IDLE;
        end
      end
    endcase
  endtask

  task automatic check_outs(input int k, input string tag, input logic [63:0] t,
                            input logic [2:0] f, input logic [1:0] a, input logic r, input logic g);
    logic [63:0] et;
    logic [2:0]  ef;
    et = '0;
    ef = '0;
    for (int i = 0; i < N; i++) begin
      et = et | (64'(m_tm[k][i]) << (i * c_tw[k]));
      ef[i] = (m_fl[k][i] != 0);
    end
    check($sformatf("%s u%0d time_out", tag, k), t, et);
    check($sformatf("%s u%0d flag", tag, k), 64'(f), 64'(ef));
    check($sformatf("%s u%0d active", tag, k), 64'(a), 64'(m_act[k]));
    check($sformatf("%s u%0d running", tag, k), 64'(r), 64'(m_st[k] == P_RUN));
    check($sformatf("%s u%0d game_over", tag, k), 64'(g), 64'(m_st[k] == P_OVER));
  endtask

  task automatic check_all(input string tag);
    check_outs(0, tag, 64'(if0.time_out), if0.flag, if0.active, if0.running, if0.game_over);
    check_outs(1, tag, 64'(if1.time_out), if1.flag, if1.active, if1.running, if1.game_over);
    check_outs(2, tag, 64'(if2.time_out), if2.flag, if2.active, if2.running, if2.game_over);
    check_outs(3, tag, 64'(if3.time_out), if3.flag, if3.active, if3.running, if3.game_over);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    for (int k = 0; k < NI; k++) model_step(k);
    #1;
    check_all(tag);
  endtask

  int pause_hold;

  initial begin
    start_s = 1'b0; pause_s = 1'b0; load_s = 1'b0; press_s = '0;
    pause_hold = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Start, then an immediate move by player 0 (saturates the narrow clock).
    start_s = 1'b1;
    cycle("start");
    press_s = 3'b001;
    cycle("first_press");
    press_s = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (pause_hold > 0) begin
        pause_hold--;
        pause_s = 1'b1;
      end else begin
        pause_s = ($urandom_range(0, 24) == 0);
        if (pause_s) pause_hold = $urandom_range(1, 10);
      end
      start_s = ($urandom_range(0, 3) != 0);
      load_s  = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) press_s[i] = ($urandom_range(0, 4) == 0);
      // Aim a move at the very tick that expires the last unit of time.
      for (int k = 0; k < 2; k++) begin
        if (m_st[k] == P_RUN && m_pre[k] == DIV - 1 && m_tm[k][m_act[k]] == 1 &&
            $urandom_range(0, 1) == 1)
          press_s[m_act[k]] = 1'b1;
      end
      cycle("rand");
      if (cyc == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
